// File: rtl/iq_acq_pkg.sv
// Shared constants for the IQ acquisition sequencer: one-hot state encoding
// and the smallest decimation factor the decimator supports.
package iq_acq_pkg;

   localparam int MIN_DEC_FACT = 3;

   localparam logic [5:0] ST_IDLE      = 6'b000001;
   localparam logic [5:0] ST_ARM       = 6'b000010;
   localparam logic [5:0] ST_WAIT_GATE = 6'b000100;
   localparam logic [5:0] ST_ACQ       = 6'b001000;
   localparam logic [5:0] ST_ECHO_END  = 6'b010000;
   localparam logic [5:0] ST_DONE      = 6'b100000;

endpackage

// File: rtl/iq_acq_sequencer.sv
// Sequences a multi-echo I/Q acquisition: arms the decimator, waits for each
// gate window, forwards decimated words into the FIFO and reports status.
module iq_acq_sequencer
   import iq_acq_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEC_WIDTH  = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  start,
   input  logic                  abort,
   input  logic [DEC_WIDTH-1:0]  dec_fact_in,
   input  logic [CNT_WIDTH-1:0]  echo_num_in,
   input  logic [CNT_WIDTH-1:0]  samp_num_in,
   input  logic                  acq_gate,
   output logic [DEC_WIDTH-1:0]  dec_fact_out,
   output logic                  dec_in_valid,
   input  logic                  dec_out_valid,
   input  logic [DATA_WIDTH-1:0] dec_dataout,
   output logic                  fifo_wr,
   output logic [DATA_WIDTH-1:0] fifo_data,
   input  logic                  fifo_full,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic                  short_echo,
   output logic [CNT_WIDTH-1:0]  echo_idx
);

   function automatic logic [DEC_WIDTH-1:0] clamp_dec(input logic [DEC_WIDTH-1:0] f);
      if (f < DEC_WIDTH'(MIN_DEC_FACT))
         return DEC_WIDTH'(MIN_DEC_FACT);
      return f;
   endfunction

   logic [5:0]           state;
   logic [CNT_WIDTH-1:0] echo_num_r;
   logic [CNT_WIDTH-1:0] samp_num_r;
   logic [CNT_WIDTH:0]   word_cnt;
   logic [CNT_WIDTH:0]   word_cnt_nxt;
   logic [CNT_WIDTH:0]   word_target;
   logic                 hit_target;
   logic                 gate_q;
   logic                 gate_rise;
   logic                 last_echo;

   // Each decimated pair is two words (I then Q).
   assign word_target  = {samp_num_r, 1'b0};
   assign word_cnt_nxt = word_cnt + (CNT_WIDTH+1)'(dec_out_valid);
   assign hit_target   = (word_cnt_nxt == word_target);
   assign gate_rise    = acq_gate && !gate_q;
   assign last_echo    = (echo_idx == echo_num_r - CNT_WIDTH'(1));

   assign dec_in_valid = (state == ST_ACQ);
   assign busy         = (state != ST_IDLE);
   assign done         = (state == ST_DONE);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state        <= ST_IDLE;
         dec_fact_out <= DEC_WIDTH'(MIN_DEC_FACT);
         echo_num_r   <= '0;
         samp_num_r   <= '0;
         word_cnt     <= '0;
         gate_q       <= 1'b0;
         fifo_wr      <= 1'b0;
         fifo_data    <= '0;
         overflow     <= 1'b0;
         short_echo   <= 1'b0;
         echo_idx     <= '0;
      end else begin
         fifo_wr <= 1'b0;
         gate_q  <= acq_gate;
         // abort preempts every state transition and suppresses the write
         if (abort && state != ST_IDLE) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start && !abort) begin
                     dec_fact_out <= clamp_dec(dec_fact_in);
                     echo_num_r   <= echo_num_in;
                     samp_num_r   <= samp_num_in;
                     word_cnt     <= '0;
                     overflow     <= 1'b0;
                     short_echo   <= 1'b0;
                     echo_idx     <= '0;
                     if (echo_num_in == '0 || samp_num_in == '0)
                        state <= ST_DONE;
                     else
                        state <= ST_ARM;
                  end
               end
               ST_ARM: begin
                  state <= ST_WAIT_GATE;
               end
               ST_WAIT_GATE: begin
                  if (gate_rise)
                     state <= ST_ACQ;
               end
               ST_ACQ: begin
                  if (dec_out_valid) begin
                     word_cnt <= word_cnt_nxt;
                     if (fifo_full) begin
                        overflow <= 1'b1;
                     end else begin
                        fifo_wr   <= 1'b1;
                        fifo_data <= dec_dataout;
                     end
                  end
                  // reaching the target wins over a gate closing in the same cycle
                  if (hit_target) begin
                     state <= ST_ECHO_END;
                  end else if (!acq_gate) begin
                     short_echo <= 1'b1;
                     state      <= ST_ECHO_END;
                  end
               end
               ST_ECHO_END: begin
                  word_cnt <= '0;
                  if (last_echo) begin
                     state <= ST_DONE;
                  end else begin
                     echo_idx <= echo_idx + CNT_WIDTH'(1);
                     state    <= ST_WAIT_GATE;
                  end
               end
               ST_DONE: begin
                  state <= ST_IDLE;
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_iq_acq_sequencer.sv
// Bench for iq_acq_sequencer: decimator/FIFO behavioural model plus directed
// and randomized acquisition scenarios.
module tb_iq_acq_sequencer;

   localparam int DW = 32;
   localparam int FW = 16;
   localparam int CW = 16;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          start;
   logic          abort;
   logic [FW-1:0] dec_fact_in;
   logic [CW-1:0] echo_num_in;
   logic [CW-1:0] samp_num_in;
   logic          acq_gate;
   logic [FW-1:0] dec_fact_out;
   logic          dec_in_valid;
   logic          dec_out_valid = 1'b0;
   logic [DW-1:0] dec_dataout = '0;
   logic          fifo_wr;
   logic [DW-1:0] fifo_data;
   logic          fifo_full = 1'b0;
   logic          busy;
   logic          done;
   logic          overflow;
   logic          short_echo;
   logic [CW-1:0] echo_idx;

   iq_acq_sequencer #(.DATA_WIDTH(DW), .DEC_WIDTH(FW), .CNT_WIDTH(CW)) dut (
      .CLK(CLK), .RESET(RESET), .start(start), .abort(abort),
      .dec_fact_in(dec_fact_in), .echo_num_in(echo_num_in), .samp_num_in(samp_num_in),
      .acq_gate(acq_gate), .dec_fact_out(dec_fact_out), .dec_in_valid(dec_in_valid),
      .dec_out_valid(dec_out_valid), .dec_dataout(dec_dataout), .fifo_wr(fifo_wr),
      .fifo_data(fifo_data), .fifo_full(fifo_full), .busy(busy), .done(done),
      .overflow(overflow), .short_echo(short_echo), .echo_idx(echo_idx)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_err = 0;

   // Observation logs, only ever appended to; tests work on snapshots.
   logic [DW-1:0] got_q[$];
   logic [DW-1:0] exp_q[$];
   int            emitted = 0;
   int            full_cnt = 0;
   int            done_cnt = 0;
   int            fact_err = 0;
   int            force_full_idx = -1;
   int            full_rate = 0;
   bit            tail_en = 1'b0;
   logic [FW-1:0] exp_fact = 16'd3;
   int            phase = 0;
   logic          prev_div = 1'b0;
   int            g0, e0, em0, d0, f0, fc0;

   // Decimator: one word every dec_fact_out enabled cycles, restarts when
   // disabled, optionally emits one pipeline-tail word after disable.
   // FIFO: full is decided per presented word.
   always @(negedge CLK) begin
      dec_out_valid = 1'b0;
      fifo_full     = 1'b0;
      if (dec_in_valid) begin
         phase = phase + 1;
         if (phase >= int'(dec_fact_out)) begin
            phase         = 0;
            dec_out_valid = 1'b1;
            dec_dataout   = $urandom;
            fifo_full     = (emitted == force_full_idx) ||
                            (int'($urandom_range(0, 99)) < full_rate);
            if (fifo_full) full_cnt = full_cnt + 1;
            else           exp_q.push_back(dec_dataout);
            emitted = emitted + 1;
         end
      end else begin
         phase = 0;
         if (prev_div && tail_en) begin
            dec_out_valid = 1'b1;
            dec_dataout   = 32'hDEAD_0000 | 32'($urandom_range(0, 65535));
         end
      end
      prev_div = dec_in_valid;
   end

   always @(negedge CLK) begin
      if (fifo_wr) got_q.push_back(fifo_data);
      if (done) done_cnt = done_cnt + 1;
      if (busy && dec_fact_out !== exp_fact) fact_err = fact_err + 1;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge CLK);
      #1;
   endtask

   task automatic snap();
      g0 = got_q.size(); e0 = exp_q.size(); em0 = emitted;
      d0 = done_cnt; f0 = fact_err; fc0 = full_cnt;
   endtask

   task automatic run_acq(input int f, input int e, input int s, input int glen);
      dec_fact_in = FW'(f); echo_num_in = CW'(e); samp_num_in = CW'(s);
      exp_fact = (f < 3) ? 16'd3 : FW'(f);
      start = 1'b1; cyc(1); start = 1'b0;
      for (int k = 0; k < e; k++) begin
         acq_gate = 1'b0; cyc(4);
         acq_gate = 1'b1; cyc(glen);
      end
      acq_gate = 1'b0;
      for (int i = 0; i < 500 && busy; i++) cyc(1);
   endtask

   task automatic test_reset();
      RESET = 1'b1; cyc(3);
      if ({busy, done, dec_in_valid, fifo_wr, overflow, short_echo} !== 6'b0) begin
         $display("FAIL reset_ctrl: got %b want 000000",
                  {busy, done, dec_in_valid, fifo_wr, overflow, short_echo});
         n_err++;
      end
      n_cmp++;
      if (fifo_data !== '0 || echo_idx !== '0 || dec_fact_out !== 16'd3) begin
         $display("FAIL reset_data: fifo_data=%h echo_idx=%0d fact=%0d want 0/0/3",
                  fifo_data, echo_idx, dec_fact_out);
         n_err++;
      end
      n_cmp++;
      RESET = 1'b0; cyc(2);
   endtask

   task automatic test_nominal();
      int nw, bad;
      snap(); tail_en = 1'b1; full_rate = 0; force_full_idx = -1;
      run_acq(4, 2, 3, 40);
      nw = got_q.size() - g0; bad = 0;
      if (nw != 12 || exp_q.size() - e0 != 12) begin
         $display("FAIL nom_writes: got %0d want 12", nw); n_err++;
      end
      n_cmp++;
      for (int i = 0; i < nw && i < exp_q.size() - e0; i++)
         if (got_q[g0+i] !== exp_q[e0+i]) bad++;
      if (bad != 0) begin
         $display("FAIL nom_order: %0d words differ, want 0", bad); n_err++;
      end
      n_cmp++;
      if (done_cnt - d0 != 1) begin
         $display("FAIL nom_done: got %0d pulses want 1", done_cnt - d0); n_err++;
      end
      n_cmp++;
      if (overflow !== 1'b0 || short_echo !== 1'b0 || echo_idx !== 16'd1 || busy !== 1'b0) begin
         $display("FAIL nom_status: ovf=%b short=%b idx=%0d busy=%b want 0/0/1/0",
                  overflow, short_echo, echo_idx, busy);
         n_err++;
      end
      n_cmp++;
   endtask

   task automatic test_clamp();
      snap(); tail_en = 1'b0;
      run_acq(1, 1, 1, 20);
      if (fact_err - f0 != 0 || dec_fact_out !== 16'd3) begin
         $display("FAIL clamp_fact: %0d busy cycles off, final=%0d want 0/3",
                  fact_err - f0, dec_fact_out);
         n_err++;
      end
      n_cmp++;
      if (got_q.size() - g0 != 2 || done_cnt - d0 != 1) begin
         $display("FAIL clamp_writes: writes=%0d done=%0d want 2/1",
                  got_q.size() - g0, done_cnt - d0);
         n_err++;
      end
      n_cmp++;
   endtask

   task automatic test_backpressure();
      int bad;
      snap(); tail_en = 1'b1; force_full_idx = emitted + 1;
      run_acq(3, 1, 3, 30);
      force_full_idx = -1;
      if (got_q.size() - g0 != 5 || emitted - em0 != 6) begin
         $display("FAIL bp_count: writes=%0d words=%0d want 5/6",
                  got_q.size() - g0, emitted - em0);
         n_err++;
      end
      n_cmp++;
      bad = 0;
      for (int i = 0; i < got_q.size() - g0 && i < exp_q.size() - e0; i++)
         if (got_q[g0+i] !== exp_q[e0+i]) bad++;
      if (bad != 0 || overflow !== 1'b1 || done_cnt - d0 != 1) begin
         $display("FAIL bp_status: bad=%0d ovf=%b done=%0d want 0/1/1",
                  bad, overflow, done_cnt - d0);
         n_err++;
      end
      n_cmp++;
   endtask

   task automatic test_short_gate();
      int bad;
      snap(); tail_en = 1'b1;
      dec_fact_in = 16'd3; echo_num_in = 16'd2; samp_num_in = 16'd10; exp_fact = 16'd3;
      start = 1'b1; cyc(1); start = 1'b0;
      acq_gate = 1'b0; cyc(4);
      acq_gate = 1'b1; cyc(13);
      acq_gate = 1'b0; cyc(10);
      if (short_echo !== 1'b1 || busy !== 1'b1 || dec_in_valid !== 1'b0 ||
          echo_idx !== 16'd1 || emitted - em0 != 4) begin
         $display("FAIL short_mid: short=%b busy=%b div=%b idx=%0d words=%0d want 1/1/0/1/4",
                  short_echo, busy, dec_in_valid, echo_idx, emitted - em0);
         n_err++;
      end
      n_cmp++;
      acq_gate = 1'b1; cyc(70); acq_gate = 1'b0;
      for (int i = 0; i < 200 && busy; i++) cyc(1);
      bad = 0;
      for (int i = 0; i < got_q.size() - g0 && i < exp_q.size() - e0; i++)
         if (got_q[g0+i] !== exp_q[e0+i]) bad++;
      if (got_q.size() - g0 != 24 || bad != 0) begin
         $display("FAIL short_writes: writes=%0d bad=%0d want 24/0", got_q.size() - g0, bad);
         n_err++;
      end
      n_cmp++;
      if (done_cnt - d0 != 1 || short_echo !== 1'b1 || busy !== 1'b0) begin
         $display("FAIL short_end: done=%0d short=%b busy=%b want 1/1/0",
                  done_cnt - d0, short_echo, busy);
         n_err++;
      end
      n_cmp++;
   endtask

   task automatic test_abort();
      int i;
      snap(); tail_en = 1'b0;
      dec_fact_in = 16'd3; echo_num_in = 16'd2; samp_num_in = 16'd3; exp_fact = 16'd3;
      start = 1'b1; cyc(1); start = 1'b0;
      acq_gate = 1'b0; cyc(4); acq_gate = 1'b1; cyc(30);
      acq_gate = 1'b0; cyc(4); acq_gate = 1'b1;
      for (i = 0; i < 20 && !dec_in_valid; i++) cyc(1);
      if (dec_in_valid !== 1'b1 || echo_idx !== 16'd1) begin
         $display("FAIL abort_reach: div=%b idx=%0d want 1/1", dec_in_valid, echo_idx);
         n_err++;
      end
      n_cmp++;
      abort = 1'b1; start = 1'b1; cyc(1); abort = 1'b0; start = 1'b0;
      if (busy !== 1'b0 || dec_in_valid !== 1'b0 || echo_idx !== 16'd1) begin
         $display("FAIL abort_idle: busy=%b div=%b idx=%0d want 0/0/1",
                  busy, dec_in_valid, echo_idx);
         n_err++;
      end
      n_cmp++;
      cyc(5);
      abort = 1'b1; start = 1'b1; cyc(1); abort = 1'b0; start = 1'b0; cyc(1);
      acq_gate = 1'b0;
      if (busy !== 1'b0 || done_cnt - d0 != 0 || got_q.size() - g0 != 6) begin
         $display("FAIL abort_after: busy=%b done=%0d writes=%0d want 0/0/6",
                  busy, done_cnt - d0, got_q.size() - g0);
         n_err++;
      end
      n_cmp++;
   endtask

   task automatic test_zero_counts();
      snap();
      dec_fact_in = 16'd5; echo_num_in = 16'd0; samp_num_in = 16'd4; exp_fact = 16'd5;
      start = 1'b1; cyc(1); start = 1'b0;
      if (done !== 1'b1 || busy !== 1'b1 || echo_idx !== 16'd0) begin
         $display("FAIL zero_done: done=%b busy=%b idx=%0d want 1/1/0", done, busy, echo_idx);
         n_err++;
      end
      n_cmp++;
      cyc(1);
      if (done !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL zero_idle: done=%b busy=%b want 0/0", done, busy); n_err++;
      end
      n_cmp++;
      echo_num_in = 16'd2; samp_num_in = 16'd0;
      start = 1'b1; cyc(1); start = 1'b0; cyc(3);
      if (done_cnt - d0 != 2 || got_q.size() - g0 != 0 || fact_err - f0 != 0) begin
         $display("FAIL zero_totals: done=%0d writes=%0d facterr=%0d want 2/0/0",
                  done_cnt - d0, got_q.size() - g0, fact_err - f0);
         n_err++;
      end
      n_cmp++;
   endtask

   task automatic test_reset_mid_acq();
      int gn, i;
      snap(); tail_en = 1'b0; force_full_idx = emitted;
      dec_fact_in = 16'd3; echo_num_in = 16'd1; samp_num_in = 16'd10; exp_fact = 16'd3;
      start = 1'b1; cyc(1); start = 1'b0;
      acq_gate = 1'b0; cyc(4); acq_gate = 1'b1;
      for (i = 0; i < 60 && emitted - em0 < 3; i++) cyc(1);
      cyc(1);
      force_full_idx = -1;
      if (overflow !== 1'b1 || busy !== 1'b1) begin
         $display("FAIL rmid_pre: ovf=%b busy=%b want 1/1", overflow, busy); n_err++;
      end
      n_cmp++;
      RESET = 1'b1; cyc(1);
      if ({busy, done, dec_in_valid, fifo_wr, overflow, short_echo} !== 6'b0 ||
          fifo_data !== '0 || echo_idx !== '0 || dec_fact_out !== 16'd3) begin
         $display("FAIL rmid_reset: ctrl=%b data=%h idx=%0d fact=%0d want 000000/0/0/3",
                  {busy, done, dec_in_valid, fifo_wr, overflow, short_echo},
                  fifo_data, echo_idx, dec_fact_out);
         n_err++;
      end
      n_cmp++;
      RESET = 1'b0; gn = got_q.size(); cyc(30);
      acq_gate = 1'b0;
      if (got_q.size() != gn || busy !== 1'b0) begin
         $display("FAIL rmid_after: writes=%0d busy=%b want 0/0", got_q.size() - gn, busy);
         n_err++;
      end
      n_cmp++;
   endtask

   task automatic test_random();
      int f, e, s, glen, bad, fe;
      for (int it = 0; it < 6; it++) begin
         f = $urandom_range(0, 6); e = $urandom_range(1, 3); s = $urandom_range(1, 4);
         fe = (f < 3) ? 3 : f;
         glen = 2 * s * fe + 8;
         snap(); tail_en = $urandom_range(0, 1); full_rate = 25;
         run_acq(f, e, s, glen);
         full_rate = 0;
         bad = 0;
         for (int i = 0; i < got_q.size() - g0 && i < exp_q.size() - e0; i++)
            if (got_q[g0+i] !== exp_q[e0+i]) bad++;
         if (got_q.size() - g0 != exp_q.size() - e0 || bad != 0 || emitted - em0 != 2*s*e) begin
            $display("FAIL rnd%0d_data: writes=%0d exp=%0d bad=%0d words=%0d want words=%0d",
                     it, got_q.size() - g0, exp_q.size() - e0, bad, emitted - em0, 2*s*e);
            n_err++;
         end
         n_cmp++;
         if (done_cnt - d0 != 1 || echo_idx !== CW'(e-1) || short_echo !== 1'b0 ||
             overflow !== (full_cnt - fc0 > 0) || fact_err - f0 != 0 || busy !== 1'b0) begin
            $display("FAIL rnd%0d_status: done=%0d idx=%0d short=%b ovf=%b facterr=%0d busy=%b want 1/%0d/0/%0b/0/0",
                     it, done_cnt - d0, echo_idx, short_echo, overflow, fact_err - f0, busy,
                     e - 1, (full_cnt - fc0 > 0));
            n_err++;
         end
         n_cmp++;
      end
   endtask

   initial begin
      RESET = 1'b1; start = 1'b0; abort = 1'b0; acq_gate = 1'b0;
      dec_fact_in = '0; echo_num_in = '0; samp_num_in = '0;
      test_reset();
      test_nominal();
      test_clamp();
      test_backpressure();
      test_short_gate();
      test_abort();
      test_zero_counts();
      test_reset_mid_acq();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
